// File: rtl/cache_wb_buffer.sv
// Victim write-back buffer: queues dirty evicted lines in FIFO order, drains them to
// memory over a valid/ready channel and lets refills snoop queued lines.
module cache_wb_buffer #(
    parameter int NUM_ENTRIES = 2,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int OFFS_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_valid_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [LINE_W-1:0] push_data_i,
    output logic              push_ready_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ready_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              snoop_hit_o,
    output logic [LINE_W-1:0] snoop_data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = PTR_W + 1;
    localparam int LA_W  = ADDR_W - OFFS_W;

    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    logic [LA_W-1:0]        addr_mem_r [NUM_ENTRIES];
    logic [LINE_W-1:0]      data_mem_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    drain_state_t           state_r;
    logic                   mem_valid_r;
    logic                   full_s;
    logic                   push_fire_s;
    logic                   drain_fire_s;
    logic                   snoop_hit_s;
    logic [LINE_W-1:0]      snoop_data_s;
    logic [PTR_W-1:0]       snoop_idx_s;
    logic                   unused_offs_s;

    // Offset bits of incoming addresses carry no meaning at line granularity.
    assign unused_offs_s = ^{push_addr_i[OFFS_W-1:0], snoop_addr_i[OFFS_W-1:0]};

    assign full_s       = (count_r == CNT_W'(NUM_ENTRIES));
    assign full_o       = full_s;
    assign empty_o      = (count_r == {CNT_W{1'b0}});
    assign push_ready_o = ~full_s;
    assign push_fire_s  = push_valid_i & ~full_s;
    assign drain_fire_s = mem_valid_r & mem_ready_i;

    assign mem_valid_o  = mem_valid_r;
    assign mem_addr_o   = {addr_mem_r[rd_ptr_r], {OFFS_W{1'b0}}};
    assign mem_data_o   = data_mem_r[rd_ptr_r];
    assign snoop_hit_o  = snoop_hit_s;
    assign snoop_data_o = snoop_data_s;

    // Occupancy after this cycle's push and drain fires.
    always_comb begin
        count_next_s = count_r;
        case ({push_fire_s, drain_fire_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Line storage is written only on a push fire and is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push_fire_s) begin
            addr_mem_r[wr_ptr_r] <= push_addr_i[ADDR_W-1:OFFS_W];
            data_mem_r[wr_ptr_r] <= push_data_i;
        end
    end

    // Valid bits, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r  <= {NUM_ENTRIES{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_fire_s) begin
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end
            if (drain_fire_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Drain FSM; mem_valid is a register so the request stays stable until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= DRAIN_IDLE;
            mem_valid_r <= 1'b0;
        end else begin
            case (state_r)
                DRAIN_IDLE: begin
                    if (count_r != {CNT_W{1'b0}}) begin
                        state_r     <= DRAIN_REQ;
                        mem_valid_r <= 1'b1;
                    end
                end
                DRAIN_REQ: begin
                    if (drain_fire_s && (count_next_s == {CNT_W{1'b0}})) begin
                        state_r     <= DRAIN_IDLE;
                        mem_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= DRAIN_IDLE;
                    mem_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Walk oldest to newest so the most recent matching copy of a line wins.
    always_comb begin
        snoop_hit_s  = 1'b0;
        snoop_data_s = {LINE_W{1'b0}};
        snoop_idx_s  = rd_ptr_r;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            snoop_idx_s = rd_ptr_r + PTR_W'(k);
            if (valid_r[snoop_idx_s] &&
                (addr_mem_r[snoop_idx_s] == snoop_addr_i[ADDR_W-1:OFFS_W])) begin
                snoop_hit_s  = 1'b1;
                snoop_data_s = data_mem_r[snoop_idx_s];
            end else begin
                snoop_hit_s  = snoop_hit_s;
                snoop_data_s = snoop_data_s;
            end
        end
    end

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Directed and scoreboard-checked bench for the victim write-back buffer.
module tb_cache_wb_buffer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         push_valid_i;
    logic [31:0]  push_addr_i;
    logic [127:0] push_data_i;
    logic         push_ready_o;
    logic         mem_valid_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_data_o;
    logic         mem_ready_i;
    logic [31:0]  snoop_addr_i;
    logic         snoop_hit_o;
    logic [127:0] snoop_data_o;
    logic         empty_o;
    logic         full_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [159:0] sb_q[$];
    logic [159:0] sb_head;

    localparam logic [127:0] D1 = {4{32'h1111_1111}};
    localparam logic [127:0] D2 = {4{32'h2222_2222}};
    localparam logic [127:0] D3 = {4{32'h3333_3333}};
    localparam logic [127:0] D4 = {4{32'h4444_4444}};
    localparam logic [127:0] D5 = {4{32'h5555_5555}};
    localparam logic [127:0] D6 = {4{32'h6666_6666}};
    localparam logic [127:0] D7 = {4{32'h7777_7777}};
    localparam logic [127:0] D8 = {4{32'h8888_8888}};

    cache_wb_buffer #(
        .NUM_ENTRIES(2), .ADDR_W(32), .LINE_W(128), .OFFS_W(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_valid_i(push_valid_i), .push_addr_i(push_addr_i),
        .push_data_i(push_data_i), .push_ready_o(push_ready_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
        .snoop_addr_i(snoop_addr_i), .snoop_hit_o(snoop_hit_o),
        .snoop_data_o(snoop_data_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push(input logic [31:0] a, input logic [127:0] d);
        push_valid_i = 1'b1;
        push_addr_i  = a;
        push_data_i  = d;
    endtask

    initial begin
        int beats;
        rst_ni = 1'b1; push_valid_i = 1'b0; push_addr_i = 32'h0; push_data_i = 128'h0;
        mem_ready_i = 1'b0; snoop_addr_i = 32'h0000_1230;
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_mem_valid", mem_valid_o, 1'b0);
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_full", full_o, 1'b0);
        chk("rst_push_ready", push_ready_o, 1'b1);
        chk("rst_snoop_hit", snoop_hit_o, 1'b0);
        chk("rst_snoop_data", snoop_data_o, 128'h0);
        rst_ni = 1'b1;

        // 1: single push, presented one cycle after the push edge
        push(32'h0000_1230, D1);
        tick();
        push_valid_i = 1'b0;
        chk("t1_empty", empty_o, 1'b0);
        chk("t1_valid_not_yet", mem_valid_o, 1'b0);
        tick();
        chk("t1_mem_valid", mem_valid_o, 1'b1);
        chk("t1_mem_addr", mem_addr_o, 32'h0000_1230);
        chk("t1_mem_data", mem_data_o, D1);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        chk("t1_drained_valid", mem_valid_o, 1'b0);
        chk("t1_drained_empty", empty_o, 1'b1);

        // 2: fill, drop a push while full, then drain back-to-back
        push(32'h0000_2345, D2);
        tick();
        push(32'h0000_3450, D3);
        tick();
        chk("t2_full", full_o, 1'b1);
        chk("t2_push_ready", push_ready_o, 1'b0);
        chk("t2_head_addr", mem_addr_o, 32'h0000_2340);
        push(32'h0000_4440, D4);
        tick();
        push_valid_i = 1'b0;
        chk("t2_still_full", full_o, 1'b1);
        chk("t2_head_stable", mem_data_o, D2);
        mem_ready_i = 1'b1;
        tick();
        chk("t2_second_valid", mem_valid_o, 1'b1);
        chk("t2_second_addr", mem_addr_o, 32'h0000_3450);
        chk("t2_second_data", mem_data_o, D3);
        tick();
        chk("t2_idle_valid", mem_valid_o, 1'b0);
        chk("t2_idle_empty", empty_o, 1'b1);
        tick();
        mem_ready_i = 1'b0;
        chk("t2_d_dropped", empty_o, 1'b1);

        // 3: full with push and drain both requested
        push(32'h0000_5000, D5);
        tick();
        push(32'h0000_6000, D6);
        tick();
        chk("t3_full", full_o, 1'b1);
        push(32'h0000_7000, D7);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        chk("t3_ready_back", push_ready_o, 1'b1);
        chk("t3_head_f", mem_addr_o, 32'h0000_6000);
        tick();
        push_valid_i = 1'b0;
        chk("t3_refull", full_o, 1'b1);
        mem_ready_i = 1'b1;
        tick();
        chk("t3_g_addr", mem_addr_o, 32'h0000_7000);
        chk("t3_g_data", mem_data_o, D7);
        tick();
        mem_ready_i = 1'b0;
        chk("t3_empty", empty_o, 1'b1);

        // 4: duplicate line, newest copy wins the snoop; drains oldest first
        push(32'h0000_1230, D1);
        tick();
        push(32'h0000_1234, D2);
        tick();
        push_valid_i = 1'b0;
        snoop_addr_i = 32'h0000_1238;
        #1;
        chk("t4_snoop_hit", snoop_hit_o, 1'b1);
        chk("t4_snoop_data", snoop_data_o, D2);
        snoop_addr_i = 32'h0000_9990;
        #1;
        chk("t4_miss_hit", snoop_hit_o, 1'b0);
        chk("t4_miss_data", snoop_data_o, 128'h0);
        snoop_addr_i = 32'h0000_1230;
        mem_ready_i  = 1'b1;
        #1;
        chk("t4_drain_hit", snoop_hit_o, 1'b1);
        chk("t4_first_out", mem_data_o, D1);
        tick();
        chk("t4_second_out", mem_data_o, D2);
        chk("t4_remaining_snoop", snoop_data_o, D2);
        tick();
        mem_ready_i = 1'b0;
        chk("t4_gone_hit", snoop_hit_o, 1'b0);
        chk("t4_empty", empty_o, 1'b1);

        // 5: reset while a request is pending
        push(32'h0000_8000, D8);
        tick();
        push_valid_i = 1'b0;
        tick();
        chk("t5_pending", mem_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("t5_valid_drop", mem_valid_o, 1'b0);
        chk("t5_empty", empty_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_ready_i = 1'b1;
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_valid_o) beats++;
            tick();
        end
        mem_ready_i = 1'b0;
        chk("t5_no_beat", beats, 0);

        // 6: random traffic against a scoreboard FIFO
        for (int cyc = 0; cyc < 1000; cyc++) begin
            push_valid_i = ($urandom_range(0, 1) == 0);
            push_addr_i  = $urandom_range(0, 7) << 4 | $urandom_range(0, 15);
            push_data_i  = {$urandom, $urandom, $urandom, $urandom};
            mem_ready_i  = ($urandom_range(0, 9) < 3);
            if (push_valid_i && push_ready_o)
                sb_q.push_back({push_addr_i & 32'hFFFF_FFF0, push_data_i});
            if (mem_valid_o && mem_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("t6_unexpected_beat", {mem_addr_o, mem_data_o}, 160'h0);
                end else begin
                    sb_head = sb_q.pop_front();
                    chk("t6_beat", {mem_addr_o, mem_data_o}, sb_head);
                end
            end
            tick();
        end
        push_valid_i = 1'b0;
        mem_ready_i  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mem_valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("t6_extra_beat", {mem_addr_o, mem_data_o}, 160'h0);
                end else begin
                    sb_head = sb_q.pop_front();
                    chk("t6_tail_beat", {mem_addr_o, mem_data_o}, sb_head);
                end
            end
            tick();
        end
        mem_ready_i = 1'b0;
        chk("t6_all_written", sb_q.size(), 0);
        chk("t6_final_empty", empty_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
